// File: rtl/l1_l2_arbiter.sv
// Arbitrates N L1 caches onto a single L2 port: one owner at a time, optional
// write-back before the line fill, and a one-cycle completion pulse to the owner.
module l1_l2_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int TAG_W      = 22,
    parameter int INDEX_W    = 4,
    parameter int DATA_W     = 512,
    parameter int FIXED_PRIO = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS-1:0]           read_i,
    input  logic [N_PORTS-1:0]           write_i,
    input  logic [N_PORTS*TAG_W-1:0]     tag_i,
    input  logic [N_PORTS*INDEX_W-1:0]   index_i,
    input  logic [N_PORTS*TAG_W-1:0]     write_tag_i,
    input  logic [N_PORTS*INDEX_W-1:0]   write_index_i,
    input  logic [N_PORTS*DATA_W-1:0]    write_data_i,
    output logic [N_PORTS-1:0]           ready_o,
    output logic                         read_o,
    output logic                         write_o,
    output logic [TAG_W-1:0]             tag_o,
    output logic [INDEX_W-1:0]           index_o,
    output logic [DATA_W-1:0]            write_data_o,
    input  logic                         ready_i,
    output logic [N_PORTS-1:0]           grant_o,
    output logic                         busy_o
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [N_PORTS-1:0]  grant_q, grant_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [N_PORTS-1:0]  ready_q, ready_d;
    logic                busy_q, busy_d;

    logic [N_PORTS-1:0]  req;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    int                  cand;

    // Scan starts at rr_ptr (or port 0 in fixed mode) and wraps; first hit wins.
    always_comb begin
        req       = read_i | write_i;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (FIXED_PRIO != 0) begin
                cand = i;
            end else begin
                cand = int'(rr_ptr_q) + i;
                if (cand >= N_PORTS) cand = cand - N_PORTS;
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gidx_d = win_idx;
                    for (int i = 0; i < N_PORTS; i++) grant_d[i] = (i == int'(win_idx));
                    state_d = write_i[win_idx] ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (ready_i) state_d = read_i[gidx_q] ? S_READ : S_DONE;
            end
            S_READ: begin
                if (ready_i) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                if (int'(gidx_q) == N_PORTS - 1) rr_ptr_d = '0;
                else                             rr_ptr_d = gidx_q + 1'b1;
            end
        endcase
    end

    // Outputs are derived from the next state so they register alongside it.
    always_comb begin
        read_d  = (state_d == S_READ);
        write_d = (state_d == S_WRITE);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_DONE) ? grant_d : '0;
        tag_d   = '0;
        index_d = '0;
        wdata_d = '0;
        if (state_d == S_WRITE) begin
            tag_d   = write_tag_i[gidx_d*TAG_W +: TAG_W];
            index_d = write_index_i[gidx_d*INDEX_W +: INDEX_W];
            wdata_d = write_data_i[gidx_d*DATA_W +: DATA_W];
        end else if (state_d == S_READ) begin
            tag_d   = tag_i[gidx_d*TAG_W +: TAG_W];
            index_d = index_i[gidx_d*INDEX_W +: INDEX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            tag_q    <= '0;
            index_q  <= '0;
            wdata_q  <= '0;
            ready_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            read_q   <= read_d;
            write_q  <= write_d;
            tag_q    <= tag_d;
            index_q  <= index_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign ready_o      = ready_q;
    assign read_o       = read_q;
    assign write_o      = write_q;
    assign tag_o        = tag_q;
    assign index_o      = index_q;
    assign write_data_o = wdata_q;
    assign grant_o      = grant_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: 2-port round-robin, 2-port fixed priority
// and 4-port round-robin instances share one set of request drivers.
module tb_l1_l2_arbiter;

    localparam int TAG_W   = 22;
    localparam int INDEX_W = 4;
    localparam int DATA_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]               rd_v, wr_v;
    logic [4*TAG_W-1:0]       tag_v, wtag_v;
    logic [4*INDEX_W-1:0]     idx_v, widx_v;
    logic [4*DATA_W-1:0]      wdata_v;
    logic                     ready_a, ready_b, ready_c;

    logic [1:0]          a_ready_o, a_grant_o, b_ready_o, b_grant_o;
    logic [3:0]          c_ready_o, c_grant_o;
    logic                a_read_o, a_write_o, a_busy_o;
    logic                b_read_o, b_write_o, b_busy_o;
    logic                c_read_o, c_write_o, c_busy_o;
    logic [TAG_W-1:0]    a_tag_o, b_tag_o, c_tag_o;
    logic [INDEX_W-1:0]  a_index_o, b_index_o, c_index_o;
    logic [DATA_W-1:0]   a_wdata_o, b_wdata_o, c_wdata_o;

    int n_cmp = 0;
    int n_err = 0;

    l1_l2_arbiter #(.N_PORTS(2), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .FIXED_PRIO(0)) u_rr2 (
        .clk(clk), .rst(rst), .read_i(rd_v[1:0]), .write_i(wr_v[1:0]),
        .tag_i(tag_v[2*TAG_W-1:0]), .index_i(idx_v[2*INDEX_W-1:0]),
        .write_tag_i(wtag_v[2*TAG_W-1:0]), .write_index_i(widx_v[2*INDEX_W-1:0]),
        .write_data_i(wdata_v[2*DATA_W-1:0]), .ready_o(a_ready_o), .read_o(a_read_o),
        .write_o(a_write_o), .tag_o(a_tag_o), .index_o(a_index_o), .write_data_o(a_wdata_o),
        .ready_i(ready_a), .grant_o(a_grant_o), .busy_o(a_busy_o));

    l1_l2_arbiter #(.N_PORTS(2), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .FIXED_PRIO(1)) u_fp2 (
        .clk(clk), .rst(rst), .read_i(rd_v[1:0]), .write_i(wr_v[1:0]),
        .tag_i(tag_v[2*TAG_W-1:0]), .index_i(idx_v[2*INDEX_W-1:0]),
        .write_tag_i(wtag_v[2*TAG_W-1:0]), .write_index_i(widx_v[2*INDEX_W-1:0]),
        .write_data_i(wdata_v[2*DATA_W-1:0]), .ready_o(b_ready_o), .read_o(b_read_o),
        .write_o(b_write_o), .tag_o(b_tag_o), .index_o(b_index_o), .write_data_o(b_wdata_o),
        .ready_i(ready_b), .grant_o(b_grant_o), .busy_o(b_busy_o));

    l1_l2_arbiter #(.N_PORTS(4), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .FIXED_PRIO(0)) u_rr4 (
        .clk(clk), .rst(rst), .read_i(rd_v), .write_i(wr_v),
        .tag_i(tag_v), .index_i(idx_v), .write_tag_i(wtag_v), .write_index_i(widx_v),
        .write_data_i(wdata_v), .ready_o(c_ready_o), .read_o(c_read_o),
        .write_o(c_write_o), .tag_o(c_tag_o), .index_o(c_index_o), .write_data_o(c_wdata_o),
        .ready_i(ready_c), .grant_o(c_grant_o), .busy_o(c_busy_o));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs settle 1 time unit after the edge; inputs driven here are sampled next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic rd, input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] ix);
        rd_v[p] = rd;
        tag_v[p*TAG_W +: TAG_W] = t;
        idx_v[p*INDEX_W +: INDEX_W] = ix;
    endtask

    task automatic set_wb(input int p, input logic wr, input logic [TAG_W-1:0] t,
                          input logic [INDEX_W-1:0] ix, input logic [DATA_W-1:0] d);
        wr_v[p] = wr;
        wtag_v[p*TAG_W +: TAG_W] = t;
        widx_v[p*INDEX_W +: INDEX_W] = ix;
        wdata_v[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_v = '0; wr_v = '0;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_a_quiet(input string tag);
        check_eq({tag, "_read"},  64'(a_read_o),  64'd0);
        check_eq({tag, "_write"}, 64'(a_write_o), 64'd0);
        check_eq({tag, "_ready"}, 64'(a_ready_o), 64'd0);
        check_eq({tag, "_grant"}, 64'(a_grant_o), 64'd0);
        check_eq({tag, "_busy"},  64'(a_busy_o),  64'd0);
        check_eq({tag, "_tag"},   64'(a_tag_o),   64'd0);
        check_eq({tag, "_index"}, 64'(a_index_o), 64'd0);
        check_eq({tag, "_wdata"}, 64'(a_wdata_o), 64'd0);
    endtask

    initial begin
        logic [1:0] exp_rr[4];
        rd_v = '0; wr_v = '0; tag_v = '0; wtag_v = '0; idx_v = '0; widx_v = '0; wdata_v = '0;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;

        // Reset state and idle with no requesters
        do_reset();
        check_a_quiet("rst");
        tick();
        check_a_quiet("idle_noreq");

        // Single read on port 0
        set_rd(0, 1'b1, 22'h12345, 4'd3);
        tick();
        check_eq("rd1_read",  64'(a_read_o),  64'd1);
        check_eq("rd1_write", 64'(a_write_o), 64'd0);
        check_eq("rd1_tag",   64'(a_tag_o),   64'h12345);
        check_eq("rd1_index", 64'(a_index_o), 64'd3);
        check_eq("rd1_grant", 64'(a_grant_o), 64'b01);
        check_eq("rd1_busy",  64'(a_busy_o),  64'd1);
        tick();
        check_eq("rd1_hold",  64'(a_read_o),  64'd1);
        check_eq("rd1_nordy", 64'(a_ready_o), 64'd0);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check_eq("rd1_done_ready", 64'(a_ready_o), 64'b01);
        check_eq("rd1_done_read",  64'(a_read_o),  64'd0);
        check_eq("rd1_done_tag",   64'(a_tag_o),   64'd0);
        check_eq("rd1_done_busy",  64'(a_busy_o),  64'd1);
        set_rd(0, 1'b0, 22'h0, 4'd0);
        tick();
        check_a_quiet("rd1_idle");
        tick();
        check_a_quiet("rd1_no_regrant");

        // Write-back then fill on port 1
        set_rd(1, 1'b1, 22'hB, 4'd6);
        set_wb(1, 1'b1, 22'hA, 4'd5, 32'hDEADBEEF);
        tick();
        check_eq("wb_write", 64'(a_write_o), 64'd1);
        check_eq("wb_read",  64'(a_read_o),  64'd0);
        check_eq("wb_tag",   64'(a_tag_o),   64'hA);
        check_eq("wb_index", 64'(a_index_o), 64'd5);
        check_eq("wb_data",  64'(a_wdata_o), 64'hDEADBEEF);
        check_eq("wb_grant", 64'(a_grant_o), 64'b10);
        tick();
        check_eq("wb_hold",  64'(a_write_o), 64'd1);
        check_eq("wb_nordy", 64'(a_ready_o), 64'd0);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check_eq("fill_write", 64'(a_write_o), 64'd0);
        check_eq("fill_read",  64'(a_read_o),  64'd1);
        check_eq("fill_tag",   64'(a_tag_o),   64'hB);
        check_eq("fill_index", 64'(a_index_o), 64'd6);
        check_eq("fill_data",  64'(a_wdata_o), 64'd0);
        check_eq("fill_nordy", 64'(a_ready_o), 64'd0);
        tick();
        check_eq("fill_nordy2", 64'(a_ready_o), 64'd0);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check_eq("wb_done_ready", 64'(a_ready_o), 64'b10);
        set_rd(1, 1'b0, 22'h0, 4'd0);
        set_wb(1, 1'b0, 22'h0, 4'd0, 32'h0);
        tick();
        check_a_quiet("wb_idle");

        // Round-robin vs fixed priority with both ports requesting continuously
        do_reset();
        set_rd(0, 1'b1, 22'h100, 4'd1);
        set_rd(1, 1'b1, 22'h200, 4'd2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("rr_grant%0d", k), 64'(a_grant_o), 64'(exp_rr[k]));
            check_eq($sformatf("rr_tag%0d", k), 64'(a_tag_o), (exp_rr[k] == 2'b01) ? 64'h100 : 64'h200);
            check_eq($sformatf("fp_grant%0d", k), 64'(b_grant_o), 64'b01);
            ready_a = 1'b1; ready_b = 1'b1;
            tick();
            ready_a = 1'b0; ready_b = 1'b0;
            check_eq($sformatf("rr_ready%0d", k), 64'(a_ready_o), 64'(exp_rr[k]));
            check_eq($sformatf("fp_ready%0d", k), 64'(b_ready_o), 64'b01);
            tick();
            check_eq($sformatf("rr_idle_busy%0d", k), 64'(a_busy_o), 64'd0);
        end
        rd_v = '0;
        tick();

        // Grant lock while port 0's read is in flight
        do_reset();
        set_rd(0, 1'b1, 22'h111, 4'd7);
        tick();
        check_eq("lock_grant0", 64'(a_grant_o), 64'b01);
        set_rd(1, 1'b1, 22'h222, 4'd8);
        tick();
        check_eq("lock_tag1",   64'(a_tag_o),   64'h111);
        check_eq("lock_grant1", 64'(a_grant_o), 64'b01);
        tick();
        check_eq("lock_tag2",   64'(a_tag_o),   64'h111);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check_eq("lock_done_grant", 64'(a_grant_o), 64'b01);
        check_eq("lock_done_ready", 64'(a_ready_o), 64'b01);
        set_rd(0, 1'b0, 22'h0, 4'd0);
        tick();
        check_eq("lock_idle_grant", 64'(a_grant_o), 64'd0);
        tick();
        check_eq("lock_next_grant", 64'(a_grant_o), 64'b10);
        check_eq("lock_next_tag",   64'(a_tag_o),   64'h222);
        check_eq("lock_next_index", 64'(a_index_o), 64'd8);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check_eq("lock_next_ready", 64'(a_ready_o), 64'b10);
        rd_v = '0;
        tick();

        // Reset in the middle of a READ
        do_reset();
        set_rd(1, 1'b1, 22'h333, 4'd9);
        tick();
        check_eq("mid_rst_read", 64'(a_read_o), 64'd1);
        set_rd(0, 1'b1, 22'h044, 4'd4);
        rst = 1'b1;
        tick();
        check_a_quiet("mid_rst");
        rst = 1'b0;
        tick();
        check_eq("post_rst_grant", 64'(a_grant_o), 64'b01);
        check_eq("post_rst_tag",   64'(a_tag_o),   64'h044);
        check_eq("post_rst_ready", 64'(a_ready_o), 64'd0);

        // Four ports: drive rr_ptr to 2, then ports 1 and 3 compete
        do_reset();
        set_rd(1, 1'b1, 22'h501, 4'd1);
        tick();
        check_eq("p4_warm_grant", 64'(c_grant_o), 64'b0010);
        ready_c = 1'b1;
        tick();
        ready_c = 1'b0;
        check_eq("p4_warm_ready", 64'(c_ready_o), 64'b0010);
        set_rd(1, 1'b0, 22'h0, 4'd0);
        tick();
        check_eq("p4_idle_busy", 64'(c_busy_o), 64'd0);
        set_rd(1, 1'b1, 22'h501, 4'd1);
        set_rd(3, 1'b1, 22'h503, 4'd3);
        tick();
        check_eq("p4_first_grant", 64'(c_grant_o), 64'b1000);
        check_eq("p4_first_tag",   64'(c_tag_o),   64'h503);
        ready_c = 1'b1;
        tick();
        ready_c = 1'b0;
        check_eq("p4_first_ready", 64'(c_ready_o), 64'b1000);
        set_rd(3, 1'b0, 22'h0, 4'd0);
        tick();
        tick();
        check_eq("p4_second_grant", 64'(c_grant_o), 64'b0010);
        check_eq("p4_second_tag",   64'(c_tag_o),   64'h501);
        rd_v = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 The block SHALL take these parameters:
- N_PORTS, default 2, number of L1 requesters.
- TAG_W, default 22, tag width.
- INDEX_W, default 4, index width.
- DATA_W, default 512, line width.
- FIXED_PRIO, default 0; 0 selects round-robin, 1 selects fixed priority with the lowest port winning.

REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; there is one clock domain.
- rst  in  1  reset; synchronous, active-high.
- read_i  in  N_PORTS  per-port line-fill request.
- write_i  in  N_PORTS  per-port write-back request.
- tag_i  in  N_PORTS*TAG_W  per-port read tag; port p occupies bits [p*TAG_W +: TAG_W].
- index_i  in  N_PORTS*INDEX_W  per-port read index.
- write_tag_i  in  N_PORTS*TAG_W  per-port write-back tag.
- write_index_i  in  N_PORTS*INDEX_W  per-port write-back index.
- write_data_i  in  N_PORTS*DATA_W  per-port write-back line.
- ready_o  out  N_PORTS  per-port completion pulse.
- read_o  out  1  read request to L2.
- write_o  out  1  write request to L2.
- tag_o  out  TAG_W  tag to L2.
- index_o  out  INDEX_W  index to L2.
- write_data_o  out  DATA_W  write-back line to L2.
- ready_i  in  1  L2 transaction done.
- grant_o  out  N_PORTS  one-hot current owner.
- busy_o  out  1  transaction in flight.

Function
REQ-003 State machine states SHALL be IDLE, WRITE, READ and DONE.
REQ-004 All outputs SHALL be registered.
REQ-005 A port is requesting when read_i[p] | write_i[p]; requesters SHALL hold request and operands stable until they see their ready_o bit high.
REQ-006 In IDLE with at least one requester, the block SHALL latch a one-hot grant. Port selection:
- FIXED_PRIO=1: lowest-numbered requester wins.
- FIXED_PRIO=0: first requester at or above rr_ptr wins, wrapping from N_PORTS-1 to 0.
REQ-007 From IDLE, the next state SHALL be WRITE if write_i of the granted port is set, else READ; read_o or write_o SHALL assert in the cycle after the request is first sampled (1-cycle latency).
REQ-008 In WRITE:
- write_o=1, read_o=0.
- tag_o and index_o SHALL be write_tag_i and write_index_i of the granted port.
- write_data_o SHALL be write_data_i of the granted port.
REQ-009 In READ:
- read_o=1, write_o=0.
- tag_o and index_o SHALL be tag_i and index_i of the granted port.
REQ-010 On ready_i in WRITE, the block SHALL go to READ if read_i of the granted port is still set (write-back-then-fill), else to DONE; write_o SHALL drop in the next cycle.
REQ-011 On ready_i in READ, the block SHALL go to DONE and read_o SHALL drop in the next cycle.
REQ-012 DONE SHALL last exactly one cycle with ready_o[granted]=1 and all other ready_o bits 0, then return to IDLE; on leaving DONE, rr_ptr SHALL become (granted+1) mod N_PORTS.
REQ-013 Requests SHALL NOT be sampled in DONE, so a request dropped at the DONE edge is never re-granted.
REQ-014 The grant SHALL NOT change between IDLE exit and DONE exit; new or withdrawn requests from other ports during this time SHALL be ignored.
REQ-015 ready_i SHALL be ignored in IDLE and DONE.
REQ-016 busy_o SHALL be 1 in WRITE, READ and DONE.
REQ-017 grant_o SHALL be 0 in IDLE.
REQ-018 read_o and write_o SHALL never both be 1.
REQ-019 tag_o, index_o and write_data_o SHALL be 0 when neither read_o nor write_o is asserted.
REQ-020 With no requesters in IDLE, the block SHALL remain in IDLE and all outputs SHALL be 0.

Reset
REQ-021 rst high at a clk edge SHALL force, on that edge:
- state to IDLE and rr_ptr to 0;
- read_o, write_o, ready_o, grant_o and busy_o to 0;
- tag_o, index_o and write_data_o to 0.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction without issuing any ready_o pulse.
REQ-023 Request arbitration SHALL resume in the first cycle with rst low.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single read: N_PORTS=2, port0 read_i with tag 0x12345, index 3; ready_i two cycles later.
  -> read_o high one cycle after the request, with tag_o=0x12345 and index_o=3.
  -> ready_o=2'b01 for one cycle after ready_i; busy_o=0 in the following cycle.
- Write-back then fill: port1 with read_i and write_i both set, write_tag=0xA, read tag=0xB.
  -> write_o with tag_o=0xA until ready_i, then read_o with tag_o=0xB.
  -> exactly one ready_o=2'b10 pulse, issued after the second ready_i.
- Round-robin fairness: both ports hold read requests continuously, ready_i is returned each time.
  -> grant order 0,1,0,1.
  -> with FIXED_PRIO=1, grant order 0,0,0.
- Grant lock: port1 raises a request while port0's read is in flight.
  -> tag_o stays at port0's value and grant_o=01 until DONE; port1 is granted in the next IDLE.
- Reset mid-READ: rst is asserted while read_o=1.
  -> next cycle all outputs are 0 with no ready_o pulse; a request after reset is granted to port0.
- N_PORTS=4: requests on ports 1 and 3 with rr_ptr=2.
  -> port3 is granted first, then port1 (wrap-around).
